rmap_window_auth: RTL



---
 rtl/rmap_window_auth_if.sv | 59 +++++
 rtl/rmap_window_auth.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rmap_window_auth_if.sv
// Handshake and configuration bundle for rmap_window_auth (RMAP user-decode side).
// Stats outputs exist only when RMAP_WINDOW_AUTH_STATS_EN is defined.
interface rmap_window_auth_if #(
  parameter int unsigned NUM_WIN = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 24
);
  logic [7:0]              configKey;
  logic [7:0]              logicalAddress;
  logic [NUM_WIN-1:0]      winEnable;
  logic [NUM_WIN*8-1:0]    winExtAddr;
  logic [NUM_WIN*ADDR_W-1:0] winBase;
  logic [NUM_WIN*ADDR_W-1:0] winEnd;
  logic [NUM_WIN*LEN_W-1:0]  winMaxLen;
  logic [NUM_WIN*3-1:0]    winPerm;

  logic [7:0]              rmapLogicalAddress;
  logic [3:0]              rmapCommand;
  logic [7:0]              rmapKey;
  logic [7:0]              rmapExtendedAddress;
  logic [ADDR_W-1:0]       rmapAddress;
  logic [LEN_W-1:0]        rmapDataLength;
  logic                    requestAuthorization;

  logic                    authorizeAck;
  logic                    rejectAck;
  logic [7:0]              replyStatus;
  logic                    addrInvalid;
  logic                    dataLengthInvalid;
  logic                    hitValid;
  logic [3:0]              hitIndex;
`ifdef RMAP_WINDOW_AUTH_STATS_EN
  logic [15:0]             authCount;
  logic [15:0]             rejectCount;
  logic [7:0]              lastRejectStatus;
`endif

  modport master (
    output configKey, logicalAddress, winEnable, winExtAddr, winBase, winEnd,
           winMaxLen, winPerm, rmapLogicalAddress, rmapCommand, rmapKey,
           rmapExtendedAddress, rmapAddress, rmapDataLength, requestAuthorization,
    input  authorizeAck, rejectAck, replyStatus, addrInvalid, dataLengthInvalid,
           hitValid, hitIndex
`ifdef RMAP_WINDOW_AUTH_STATS_EN
    , input authCount, rejectCount, lastRejectStatus
`endif
  );

  modport slave (
    input  configKey, logicalAddress, winEnable, winExtAddr, winBase, winEnd,
           winMaxLen, winPerm, rmapLogicalAddress, rmapCommand, rmapKey,
           rmapExtendedAddress, rmapAddress, rmapDataLength, requestAuthorization,
    output authorizeAck, rejectAck, replyStatus, addrInvalid, dataLengthInvalid,
           hitValid, hitIndex
`ifdef RMAP_WINDOW_AUTH_STATS_EN
    , output authCount, rejectCount, lastRejectStatus
`endif
  );
endinterface

// File: rtl/rmap_window_auth.sv
// Multi-window RMAP authorisation: header checks, then first-match scan over NUM_WIN windows.
// Optional accept/reject statistics enabled by RMAP_WINDOW_AUTH_STATS_EN.
module rmap_window_auth #(
  parameter int unsigned NUM_WIN = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 24
) (
  input logic              clk,
  input logic              rst,
  rmap_window_auth_if.slave bus
);

  localparam int unsigned SUM_W    = ADDR_W + 1;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_WIN - 1);

  localparam logic [7:0] ST_OK       = 8'd0;
  localparam logic [7:0] ST_BAD_CMD  = 8'd2;
  localparam logic [7:0] ST_BAD_KEY  = 8'd3;
  localparam logic [7:0] ST_NO_WIN   = 8'd10;
  localparam logic [7:0] ST_RMW_LEN  = 8'd11;
  localparam logic [7:0] ST_BAD_LA   = 8'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SCAN,
    S_RESP,
    S_WAIT_DROP
  } state_t;

  state_t            r_state;
  logic [7:0]        r_la;
  logic [3:0]        r_cmd;
  logic [7:0]        r_key;
  logic [7:0]        r_ext;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [3:0]        r_idx;
  logic              r_cov_seen;
  logic              r_len_seen;

  logic              r_auth;
  logic              r_rej;
  logic [7:0]        r_status;
  logic              r_addr_inv;
  logic              r_len_inv;
  logic              r_hit;
  logic [3:0]        r_hit_idx;

  // Current window fields selected by the scan index
  logic              w_en;
  logic [7:0]        w_ext;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_end;
  logic [LEN_W-1:0]  w_maxlen;
  logic [2:0]        w_perm;

  assign w_en     = 1'(bus.winEnable >> r_idx);
  assign w_ext    = 8'(bus.winExtAddr >> (32'(r_idx) * 8));
  assign w_base   = ADDR_W'(bus.winBase >> (32'(r_idx) * ADDR_W));
  assign w_end    = ADDR_W'(bus.winEnd >> (32'(r_idx) * ADDR_W));
  assign w_maxlen = LEN_W'(bus.winMaxLen >> (32'(r_idx) * LEN_W));
  assign w_perm   = 3'(bus.winPerm >> (32'(r_idx) * 3));

  logic w_is_write;
  logic w_is_read;
  logic w_is_rmw;
  logic w_cmd_bad;
  logic w_rmw_len_ok;

  assign w_is_write   = r_cmd[3];
  assign w_is_read    = (r_cmd[3:1] == 3'b001);
  assign w_is_rmw     = (r_cmd == 4'b0111);
  assign w_cmd_bad    = !(w_is_write || w_is_read || w_is_rmw);
  assign w_rmw_len_ok = (r_len == LEN_W'(2)) || (r_len == LEN_W'(4)) ||
                        (r_len == LEN_W'(6)) || (r_len == LEN_W'(8));

  logic [SUM_W-1:0] w_sum;
  logic             w_cover;
  logic             w_end_ok;
  logic             w_len_ok;
  logic             w_perm_ok;
  logic             w_pass;
  logic             w_cov_any;
  logic             w_len_any;

  // End check is done one bit wider so addr+len cannot wrap past the window
  assign w_sum     = {1'b0, r_addr} + SUM_W'(r_len);
  assign w_cover   = w_en && (r_ext == w_ext) && (r_addr >= w_base) && (r_addr < w_end);
  assign w_end_ok  = !r_cmd[0] || (w_sum <= {1'b0, w_end});
  assign w_len_ok  = (r_len <= w_maxlen);
  assign w_perm_ok = (w_is_write && w_perm[1]) || (w_is_read && w_perm[0]) ||
                     (w_is_rmw && w_perm[2]);
  assign w_pass    = w_cover && w_end_ok && w_len_ok && w_perm_ok;
  assign w_cov_any = r_cov_seen || w_cover;
  assign w_len_any = r_len_seen || (w_cover && !(w_end_ok && w_len_ok));

`ifdef RMAP_WINDOW_AUTH_STATS_EN
  logic [15:0] r_auth_cnt;
  logic [15:0] r_rej_cnt;
  logic [7:0]  r_last_rej;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_la       <= '0;
      r_cmd      <= '0;
      r_key      <= '0;
      r_ext      <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_cov_seen <= 1'b0;
      r_len_seen <= 1'b0;
      r_auth     <= 1'b0;
      r_rej      <= 1'b0;
      r_status   <= '0;
      r_addr_inv <= 1'b0;
      r_len_inv  <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
`ifdef RMAP_WINDOW_AUTH_STATS_EN
      r_auth_cnt <= '0;
      r_rej_cnt  <= '0;
      r_last_rej <= '0;
`endif
    end else begin
      r_auth <= 1'b0;
      r_rej  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.requestAuthorization) begin
            r_la       <= bus.rmapLogicalAddress;
            r_cmd      <= bus.rmapCommand;
            r_key      <= bus.rmapKey;
            r_ext      <= bus.rmapExtendedAddress;
            r_addr     <= bus.rmapAddress;
            r_len      <= bus.rmapDataLength;
            r_addr_inv <= 1'b0;
            r_len_inv  <= 1'b0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_state    <= S_HDR;
          end
        end
        S_HDR: begin
          r_idx      <= '0;
          r_cov_seen <= 1'b0;
          r_len_seen <= 1'b0;
          if (r_la != bus.logicalAddress) begin
            r_status <= ST_BAD_LA;
            r_state  <= S_RESP;
          end else if (w_cmd_bad) begin
            r_status <= ST_BAD_CMD;
            r_state  <= S_RESP;
          end else if (r_key != bus.configKey) begin
            r_status <= ST_BAD_KEY;
            r_state  <= S_RESP;
          end else if (w_is_rmw && !w_rmw_len_ok) begin
            r_status <= ST_RMW_LEN;
            r_state  <= S_RESP;
          end else begin
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_pass) begin
            r_status  <= ST_OK;
            r_hit     <= 1'b1;
            r_hit_idx <= r_idx;
            r_state   <= S_RESP;
          end else if (r_idx == LAST_IDX) begin
            r_status   <= ST_NO_WIN;
            r_addr_inv <= !w_cov_any;
            r_len_inv  <= w_len_any;
            r_state    <= S_RESP;
          end else begin
            r_cov_seen <= w_cov_any;
            r_len_seen <= w_len_any;
            r_idx      <= r_idx + 4'd1;
          end
        end
        S_RESP: begin
          if (r_status == ST_OK) begin
            r_auth <= 1'b1;
`ifdef RMAP_WINDOW_AUTH_STATS_EN
            if (r_auth_cnt != 16'hFFFF) r_auth_cnt <= r_auth_cnt + 16'd1;
`endif
          end else begin
            r_rej <= 1'b1;
`ifdef RMAP_WINDOW_AUTH_STATS_EN
            if (r_rej_cnt != 16'hFFFF) r_rej_cnt <= r_rej_cnt + 16'd1;
            r_last_rej <= r_status;
`endif
          end
          r_state <= S_WAIT_DROP;
        end
        S_WAIT_DROP: begin
          if (!bus.requestAuthorization) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.authorizeAck      = r_auth;
  assign bus.rejectAck         = r_rej;
  assign bus.replyStatus       = r_status;
  assign bus.addrInvalid       = r_addr_inv;
  assign bus.dataLengthInvalid = r_len_inv;
  assign bus.hitValid          = r_hit;
  assign bus.hitIndex          = r_hit_idx;
`ifdef RMAP_WINDOW_AUTH_STATS_EN
  assign bus.authCount         = r_auth_cnt;
  assign bus.rejectCount       = r_rej_cnt;
  assign bus.lastRejectStatus  = r_last_rej;
`endif

endmodule
